// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x-oversample tick generator: one-cycle tick every CLK_DIV clocks,
// restartable so a receiver can phase-align to a detected start edge.
module uart_baud_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic wb_clk,
    input  logic wb_rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt_q <= '0;
        end else if (restart || cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with a one-entry valid/ready output stage.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err output (default 8N1).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 27,
    parameter int DATA_W  = 8
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(SAMPLE_MID);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    logic rx_p0, rx_p1, rx_s;
    logic tick;
    uart_state_t state_q, state_nxt;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic restart, tick_clr, tick_inc, shift_en, bit_inc, load_ok, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic perr_set, drop_q;
`endif

    // Input synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s = rx_p1;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .restart  (restart),
        .tick     (tick)
    );

    always_comb begin
        state_nxt = state_q;
        restart   = 1'b0;
        tick_clr  = 1'b0;
        tick_inc  = 1'b0;
        shift_en  = 1'b0;
        bit_inc   = 1'b0;
        load_ok   = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt = ST_START;
                    restart   = 1'b1;
                    tick_clr  = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        // Mid-start re-check rejects short glitches.
                        if (rx_s) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_DATA;
                            tick_clr  = 1'b1;
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_clr = 1'b1;
                        shift_en = 1'b1;
                        bit_inc  = 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = ST_PARITY;
`else
                            state_nxt = ST_STOP;
`endif
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_clr  = 1'b1;
                        state_nxt = ST_STOP;
                        perr_set  = (rx_s != ^shreg_q);
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_clr = 1'b1;
                        if (rx_s) begin
                            state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            load_ok   = !drop_q;
`else
                            load_ok   = 1'b1;
`endif
                        end else begin
                            state_nxt = ST_BREAK;
                            ferr_set  = 1'b1;
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
        end else begin
            state_q <= state_nxt;
            if (tick_clr) begin
                tick_cnt_q <= '0;
            end else if (tick_inc) begin
                tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
            if (restart) begin
                bit_cnt_q <= '0;
            end else if (bit_inc) begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
            if (shift_en) begin
                shreg_q <= {rx_s, shreg_q[DATA_W-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            drop_q     <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_set;
            if (restart) begin
                drop_q <= 1'b0;
            end else if (perr_set) begin
                drop_q <= 1'b1;
            end
        end
    end
`endif

    // Output stage: a completing byte loads only if the slot is empty or being handed off.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= load_ok && rx_valid && !rx_ready;
            if (load_ok && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=4 (64 clocks per bit): table of clean frames
// plus hand-written glitch, framing-error, overrun, coincident-handshake and reset sequences.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int DATA_W   = 8;
    localparam int BIT_CLKS = 16 * CLK_DIV;

    logic              wb_clk   = 1'b0;
    logic              wb_rst_n = 1'b0;
    logic              rx       = 1'b1;
    logic              rx_ready = 1'b0;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              overrun;

    always #5 wb_clk = ~wb_clk;

    uart_rx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // Event monitor: cumulative counts, sampled just after the falling edge.
    int         vcyc_n  = 0;
    int         vfall_n = 0;
    int         ferr_n  = 0;
    int         ovr_n   = 0;
    int         hs_n    = 0;
    logic [7:0] hs_data = '0;
    logic [7:0] hs_prev = '0;
    logic       vld_d   = 1'b0;

    always @(negedge wb_clk) begin
        #1;
        if (wb_rst_n) begin
            if (rx_valid) vcyc_n++;
            if (vld_d && !rx_valid) vfall_n++;
            if (frame_err) ferr_n++;
            if (overrun) ovr_n++;
            if (rx_valid && rx_ready) begin
                hs_n++;
                hs_prev = hs_data;
                hs_data = rx_data;
            end
        end
        vld_d = rx_valid;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int s_vcyc, s_vfall, s_ferr, s_ovr, s_hs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic snap();
        s_vcyc  = vcyc_n;
        s_vfall = vfall_n;
        s_ferr  = ferr_n;
        s_ovr   = ovr_n;
        s_hs    = hs_n;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge wb_clk);
    endtask

    // Drives start, 8 data bits LSB first, and stop; rx stays at the stop level afterwards.
    // rdy_at / rst_at (>= 0) raise rx_ready or pulse reset at that clock index of the frame.
    task automatic send_frame(input logic [7:0] d, input logic stopb, input int rdy_at, input int rst_at);
        logic [9:0] bits;
        bits = {stopb, d, 1'b0};
        for (int j = 0; j < 10 * BIT_CLKS; j++) begin
            @(negedge wb_clk);
            rx = bits[j / BIT_CLKS];
            if (j == rdy_at) rx_ready = 1'b1;
            if (rst_at >= 0) begin
                if (j == rst_at) wb_rst_n = 1'b0;
                if (j == rst_at + 2) begin
                    check("rst_mid_data",  {24'b0, rx_data}, 32'h0);
                    check("rst_mid_valid", {31'b0, rx_valid}, 32'h0);
                    check("rst_mid_ferr",  {31'b0, frame_err}, 32'h0);
                    check("rst_mid_ovr",   {31'b0, overrun}, 32'h0);
                end
                if (j == rst_at + 4) wb_rst_n = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopb;
        int         exp_vcyc;
        int         exp_ferr;
        int         exp_ovr;
        int         exp_hs;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{data: 8'hA5, stopb: 1'b1, exp_vcyc: 1, exp_ferr: 0, exp_ovr: 0, exp_hs: 1, exp_data: 8'hA5};
        vecs[1] = '{data: 8'h00, stopb: 1'b1, exp_vcyc: 1, exp_ferr: 0, exp_ovr: 0, exp_hs: 1, exp_data: 8'h00};
        vecs[2] = '{data: 8'hFF, stopb: 1'b1, exp_vcyc: 1, exp_ferr: 0, exp_ovr: 0, exp_hs: 1, exp_data: 8'hFF};
        vecs[3] = '{data: 8'h5A, stopb: 1'b1, exp_vcyc: 1, exp_ferr: 0, exp_ovr: 0, exp_hs: 1, exp_data: 8'h5A};

        // Reset state
        repeat (5) @(negedge wb_clk);
        check("reset_data",  {24'b0, rx_data}, 32'h0);
        check("reset_valid", {31'b0, rx_valid}, 32'h0);
        check("reset_ferr",  {31'b0, frame_err}, 32'h0);
        check("reset_ovr",   {31'b0, overrun}, 32'h0);
        check("reset_state", {29'b0, dut.state_q}, {29'b0, ST_IDLE});
        wb_rst_n = 1'b1;
        idle(20);

        // Clean 8N1 frames with the consumer always ready
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            snap();
            send_frame(vecs[i].data, vecs[i].stopb, -1, -1);
            idle(40);
            check($sformatf("vec%0d_data", i), {24'b0, hs_data}, {24'b0, vecs[i].exp_data});
            check($sformatf("vec%0d_vcyc", i), vcyc_n - s_vcyc, vecs[i].exp_vcyc);
            check($sformatf("vec%0d_hs", i), hs_n - s_hs, vecs[i].exp_hs);
            check($sformatf("vec%0d_ferr", i), ferr_n - s_ferr, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), ovr_n - s_ovr, vecs[i].exp_ovr);
        end

        // 20-clock low glitch must be rejected
        snap();
        rx = 1'b0;
        repeat (20) @(negedge wb_clk);
        idle(100);
        check("glitch_vcyc",  vcyc_n - s_vcyc, 0);
        check("glitch_ferr",  ferr_n - s_ferr, 0);
        check("glitch_ovr",   ovr_n - s_ovr, 0);
        check("glitch_state", {29'b0, dut.state_q}, {29'b0, ST_IDLE});

        // Stop bit low, then line held low (break), then a good frame
        snap();
        send_frame(8'h3C, 1'b0, -1, -1);
        repeat (200) @(negedge wb_clk);
        idle(40);
        check("ferr_pulses", ferr_n - s_ferr, 1);
        check("ferr_vcyc",   vcyc_n - s_vcyc, 0);
        snap();
        send_frame(8'h55, 1'b1, -1, -1);
        idle(40);
        check("after_break_hs",   hs_n - s_hs, 1);
        check("after_break_data", {24'b0, hs_data}, 32'h55);
        check("after_break_ferr", ferr_n - s_ferr, 0);

        // Overrun: second byte dropped while the first is held
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, -1, -1);
        idle(40);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(40);
        check("ovr_pulses", ovr_n - s_ovr, 1);
        check("ovr_data",   {24'b0, rx_data}, 32'h11);
        check("ovr_valid",  {31'b0, rx_valid}, 32'h1);
        check("ovr_hs",     hs_n - s_hs, 0);
        rx_ready = 1'b1;
        repeat (3) @(negedge wb_clk);
        check("ovr_deliver_hs",    hs_n - s_hs, 1);
        check("ovr_deliver_data",  {24'b0, hs_data}, 32'h11);
        check("ovr_deliver_valid", {31'b0, rx_valid}, 32'h0);
        rx_ready = 1'b0;

        // Handshake coincides with the next load (stop sample lands at frame clock 610)
        send_frame(8'h11, 1'b1, -1, -1);
        idle(40);
        snap();
        send_frame(8'h22, 1'b1, 610, -1);
        idle(40);
        check("coin_ovr",   ovr_n - s_ovr, 0);
        check("coin_hs",    hs_n - s_hs, 2);
        check("coin_first", {24'b0, hs_prev}, 32'h11);
        check("coin_data",  {24'b0, hs_data}, 32'h22);
        check("coin_vfall", vfall_n - s_vfall, 1);
        rx_ready = 1'b0;

        // Reset during data bit 4 of 0xF0 while a byte is held, then a fresh frame
        send_frame(8'h33, 1'b1, -1, -1);
        idle(40);
        send_frame(8'hF0, 1'b1, -1, 5 * BIT_CLKS + BIT_CLKS / 2);
        idle(40);
        check("post_rst_valid", {31'b0, rx_valid}, 32'h0);
        check("post_rst_state", {29'b0, dut.state_q}, {29'b0, ST_IDLE});
        rx_ready = 1'b1;
        snap();
        send_frame(8'h81, 1'b1, -1, -1);
        idle(40);
        check("post_rst_hs",   hs_n - s_hs, 1);
        check("post_rst_data", {24'b0, hs_data}, 32'h81);
        check("post_rst_ferr", ferr_n - s_ferr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 27, giving system clocks per 16x-oversample tick (50 MHz / 115200 baud).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving data bits per frame.
REQ-003 The block SHALL have port wb_clk, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-004 The block SHALL have port wb_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port rx_data, output, DATA_W bits: received byte.
REQ-007 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an undelivered byte.
REQ-008 The block SHALL have port rx_ready, input, 1 bit: consumer accepts rx_data.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-010 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a byte is dropped.

Function
REQ-011 The block SHALL pass rx through a 2-flop synchronizer before any use; the synchronizer flops reset to 1.
REQ-012 The block SHALL generate a one-cycle tick every CLK_DIV clocks from a free-running divider, restarted on the IDLE->START transition.
REQ-013 The FSM SHALL implement states IDLE, START, DATA, PARITY (macro-only), STOP and BREAK.
REQ-014 IDLE: a low synchronized rx SHALL move the FSM to START and clear the tick counter.
REQ-015 START: at tick 7, a high line SHALL return the FSM to IDLE (glitch rejected, no output); a low line SHALL clear the tick count and move the FSM to DATA.
REQ-016 DATA: the block SHALL sample one bit every 16 ticks at mid-bit, shifting LSB first; after DATA_W bits it SHALL go to STOP (or PARITY).
REQ-017 STOP: if the stop bit samples high, the block SHALL load the byte into the output stage and go to IDLE.
REQ-018 STOP: if the stop bit samples low, the block SHALL pulse frame_err, discard the byte and go to BREAK.
REQ-019 BREAK: the FSM SHALL wait for a high synchronized rx, then go to IDLE.
REQ-020 rx_valid SHALL rise the cycle after the stop-sample tick, and rx_data SHALL be stable while rx_valid is high.
REQ-021 A handshake SHALL occur when rx_valid && rx_ready at a clock edge; rx_valid SHALL fall the next cycle unless a new byte loads in that same cycle.
REQ-022 If a new byte completes while rx_valid is high and no handshake occurs that cycle, the block SHALL pulse overrun, retain the old byte and drop the new one.
REQ-023 If a handshake and a new-byte completion coincide, the block SHALL load the new byte, keep rx_valid high and not pulse overrun.
REQ-024 rx_ready while rx_valid is low SHALL have no effect.

Reset
REQ-025 While wb_rst_n is low, the block SHALL hold rx_data=0, rx_valid=0, frame_err=0, overrun=0, FSM=IDLE, and the divider and counters at 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL resume in IDLE and wait for a new falling edge.

Configuration
REQ-027 With UART_RX_PARITY_EN defined, the block SHALL sample one even-parity bit in PARITY after the data bits.
REQ-028 With UART_RX_PARITY_EN defined, a parity mismatch SHALL pulse output parity_err (1 bit, reset 0) for one cycle and drop the byte, with the FSM continuing to STOP.
REQ-029 With UART_RX_PARITY_EN undefined, the block SHALL have no PARITY state and no parity_err port, and frames SHALL be 8N1.

Structure
REQ-030 The shared package uart_pkg SHALL hold the FSM state enum type, OVERSAMPLE=16 and SAMPLE_MID=7.
REQ-031 The divider/tick generator SHALL be sub-module uart_baud_gen (ports wb_clk, wb_rst_n, restart, tick), reusable by the transmitter.

Verification (CLK_DIV=4, so one bit = 64 clocks)
REQ-032 The bench SHALL drive frame 0xA5 8N1 with rx_ready=1 and check rx_data=0xA5, rx_valid high for exactly 1 cycle, and no error pulses.
REQ-033 The bench SHALL send a 20-clock low glitch on rx and check that rx_valid, frame_err and overrun stay low and the FSM returns to IDLE.
REQ-034 The bench SHALL send frame 0x3C with the stop bit forced to 0, then hold rx low for 200 clocks, and check one frame_err pulse, no rx_valid, and that the next valid frame 0x55 is received.
REQ-035 The bench SHALL send 0x11 then 0x22 with rx_ready=0 and check rx_data=0x11, one overrun pulse, and that 0x11 is delivered when rx_ready rises.
REQ-036 The bench SHALL assert rx_ready in the exact cycle the second byte loads and check rx_valid stays high, rx_data=0x22, and no overrun.
REQ-037 The bench SHALL pulse wb_rst_n low at data bit 4 of 0xF0 and check all outputs at 0 and that a following 0x81 is received correctly.
